// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; WIDTH >= 2 keeps this at least one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake, operands and result of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrowOut;

    modport master (
        output start, a, b, borrowIn,
        input  busy, done, difference, borrowOut
    );

    modport slave (
        input  start, a, b, borrowIn,
        output busy, done, difference, borrowOut
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrowIn.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic diff,
    output logic borrowOut
);
    assign diff      = a ^ b ^ borrowIn;
    assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// WIDTH shift cycles per operation plus a one-cycle done state.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                resetN,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow_reg;
    logic             cell_d;
    logic             cell_bout;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] difference_q;
    logic             borrow_out_q;

    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign diff_next = {cell_d, diff_sr[WIDTH-1:1]};

    full_subtractor u_cell (
        .a         (a_reg[0]),
        .b         (b_reg[0]),
        .borrowIn  (borrow_reg),
        .diff      (cell_d),
        .borrowOut (cell_bout)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is only honoured in IDLE and DONE; SHIFT ignores it entirely.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    next_state = SHIFT;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            diff_sr      <= '0;
            borrow_reg   <= 1'b0;
            difference_q <= '0;
            borrow_out_q <= 1'b0;
        end else if (load) begin
            cnt        <= '0;
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            diff_sr    <= '0;
            borrow_reg <= bus.borrowIn;
        end else if (state == SHIFT) begin
            a_reg      <= a_reg >> 1;
            b_reg      <= b_reg >> 1;
            diff_sr    <= diff_next;
            borrow_reg <= cell_bout;
            // Visible result only moves on the final bit so it stays held otherwise.
            if (last_bit) begin
                cnt          <= '0;
                difference_q <= diff_next;
                borrow_out_q <= cell_bout;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.difference = difference_q;
    assign bus.borrowOut  = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases, exhaustive sweep, random ops.
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int accepted = 0;
    int dones    = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction wrapped to WIDTH+1 bits.
    function automatic logic [WIDTH:0] ref_sub(input int av, input int bv, input int bin);
        int r;
        r = (av - bv - bin) & ((1 << (WIDTH + 1)) - 1);
        return (WIDTH+1)'(r);
    endfunction

    task automatic issue(input int av, input int bv, input int bin, input logic [WIDTH:0] e);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("issue_wait_busy", 32'(bus.busy), 0);
        bus.start    = 1'b1;
        bus.a        = WIDTH'(av);
        bus.b        = WIDTH'(bv);
        bus.borrowIn = 1'(bin);
        exp_q.push_back(e);
        accepted++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!bus.done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(bus.done), 1);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        logic prev_done;
        logic [WIDTH:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resetN === 1'b1) begin
                if (bus.done) begin
                    dones++;
                    check("done_single_cycle", 32'(prev_done), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected done=0");
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'({bus.borrowOut, bus.difference}), 32'(e));
                    end
                end
                prev_done = bus.done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int t;
        int dn;
        int av;
        int bv;
        int bin;
        resetN       = 1'b0;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.borrowIn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_difference", 32'(bus.difference), 0);
        check("reset_borrowOut", 32'(bus.borrowOut), 0);
        resetN = 1'b1;

        // 7 - 3: latency, busy length and hold of the result
        issue(7, 3, 0, 5'b0_0100);
        bc = 0;
        t  = 0;
        while (!bus.done && t < 50) begin
            if (bus.busy) bc++;
            @(negedge clk);
            t++;
        end
        check("busy_cycles", 32'(bc), 32'(WIDTH));
        check("latency", 32'(t + 1), 32'(WIDTH + 1));
        repeat (3) @(negedge clk);
        check("hold_difference", 32'(bus.difference), 4);
        check("hold_borrowOut", 32'(bus.borrowOut), 0);
        check("idle_busy", 32'(bus.busy), 0);

        issue(3, 7, 0, 5'b1_1100);
        issue(0, 0, 1, 5'b1_1111);
        issue(15, 15, 0, 5'b0_0000);
        wait_done();

        // start during SHIFT ignored, then back-to-back accept in DONE
        issue(9, 2, 0, 5'b0_0111);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        bus.start    = 1'b1;
        bus.a        = 4'd5;
        bus.b        = 4'd6;
        bus.borrowIn = 1'b0;
        exp_q.push_back(5'b1_1111);
        accepted++;
        @(negedge clk);
        bus.start = 1'b0;
        check("back_to_back_busy", 32'(bus.busy), 1);
        wait_done();
        @(negedge clk);

        // asynchronous reset in the middle of SHIFT
        issue(10, 4, 0, 5'b0_0110);
        @(negedge clk);
        #1 resetN = 1'b0;
        void'(exp_q.pop_back());
        accepted--;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_difference", 32'(bus.difference), 0);
        check("abort_borrowOut", 32'(bus.borrowOut), 0);
        @(negedge clk);
        resetN = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 32'(dn), 0);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    issue(ia, ib, ic, ref_sub(ia, ib, ic));

        for (int k = 0; k < 150; k++) begin
            av  = int'($urandom_range(0, 15));
            bv  = int'($urandom_range(0, 15));
            bin = int'($urandom_range(0, 1));
            issue(av, bv, bin, ref_sub(av, bv, bin));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        wait_done();
        repeat (3) @(negedge clk);
        check("done_count", 32'(dones), 32'(accepted));
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
